// File: rtl/spiker_packer_pkg.sv
// Shared types and helpers for the spiker result packer.
package spiker_packer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDone
    } state_e;

    // Widest vector the popcount helper can count; callers zero-extend into it.
    localparam int unsigned POP_MAX_WIDTH = 1024;

    function automatic int unsigned popcount(input logic [POP_MAX_WIDTH-1:0] vec,
                                             input int unsigned width);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < POP_MAX_WIDTH; i++) begin
            if (i < width) n += {31'd0, vec[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/spiker_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module spiker_popcount
    import spiker_packer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]           data_i,
    output logic [$clog2(WIDTH+1)-1:0] count_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    if (WIDTH > POP_MAX_WIDTH) begin : g_width_check
        $error("spiker_popcount: WIDTH exceeds POP_MAX_WIDTH");
    end

    logic [POP_MAX_WIDTH-1:0] padded;

    always_comb begin
        padded = '0;
        padded[WIDTH-1:0] = data_i;
    end

    assign count_o = CW'(popcount(padded, WIDTH));

endmodule

// File: rtl/spiker_result_packer.sv
// Packs spike-core output (parallel snapshot or LSB-first beat stream) into the
// result register bank, with per-word write enables, frame popcount and error flags.
module spiker_result_packer
    import spiker_packer_pkg::*;
#(
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned N_REG     = 24,
    parameter int unsigned IN_WIDTH  = 8,
    localparam int unsigned DATA_WIDTH    = N_REG * REG_WIDTH,
    localparam int unsigned BEATS_PER_REG = REG_WIDTH / IN_WIDTH,
    localparam int unsigned CNT_W         = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  par_sample_i,
    input  logic [DATA_WIDTH-1:0] par_data_i,
    input  logic                  s_valid_i,
    input  logic [IN_WIDTH-1:0]   s_data_i,
    input  logic                  s_last_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [N_REG-1:0]      result_de_o,
    output logic [CNT_W-1:0]      spike_count_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  short_frame_o,
    output logic                  overflow_o,
    input  logic                  err_clr_i
);

    if (REG_WIDTH % IN_WIDTH != 0) begin : g_width_check
        $error("spiker_result_packer: IN_WIDTH must divide REG_WIDTH");
    end

    localparam int unsigned BIDX_W   = (BEATS_PER_REG > 1) ? $clog2(BEATS_PER_REG) : 1;
    localparam int unsigned WIDX_W   = (N_REG > 1) ? $clog2(N_REG) : 1;
    localparam int unsigned IN_CNT_W = $clog2(IN_WIDTH + 1);
    localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(BEATS_PER_REG - 1);
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(N_REG - 1);

    state_e                state_q;
    logic [WIDX_W-1:0]     widx_q;
    logic [BIDX_W-1:0]     bidx_q;
    logic [REG_WIDTH-1:0]  asm_q;
    logic [CNT_W-1:0]      run_cnt_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [N_REG-1:0]      de_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  done_q;
    logic                  short_q;
    logic                  ovf_q;

    logic [IN_CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]      par_cnt;
    logic [CNT_W-1:0]      run_sum;
    logic [REG_WIDTH-1:0]  beat_word;
    logic [REG_WIDTH-1:0]  word_next;
    logic                  beat_acc;

    spiker_popcount #(
        .WIDTH (IN_WIDTH)
    ) u_pop_beat (
        .data_i  (s_data_i),
        .count_o (beat_cnt)
    );

    spiker_popcount #(
        .WIDTH (DATA_WIDTH)
    ) u_pop_par (
        .data_i  (par_data_i),
        .count_o (par_cnt)
    );

    assign s_ready_o = 1'b1;
    assign beat_acc  = s_valid_i && s_ready_o;
    assign run_sum   = run_cnt_q + CNT_W'(beat_cnt);

    // Assembly register is cleared after every commit, so a partial word has zero upper bits.
    always_comb begin
        beat_word = '0;
        beat_word[bidx_q*IN_WIDTH +: IN_WIDTH] = s_data_i;
        word_next = asm_q | beat_word;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            widx_q    <= '0;
            bidx_q    <= '0;
            asm_q     <= '0;
            run_cnt_q <= '0;
            result_q  <= '0;
            de_q      <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            short_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            de_q   <= '0;
            done_q <= 1'b0;
            // Set events below are assigned later and therefore win over the clear.
            if (err_clr_i) begin
                short_q <= 1'b0;
                ovf_q   <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (beat_acc) ovf_q <= 1'b1;
                    if (par_sample_i) begin
                        result_q <= par_data_i;
                        de_q     <= '1;
                        done_q   <= 1'b1;
                        cnt_q    <= par_cnt;
                        state_q  <= StDone;
                    end else if (start_i && !abort_i) begin
                        widx_q    <= '0;
                        bidx_q    <= '0;
                        asm_q     <= '0;
                        run_cnt_q <= '0;
                        state_q   <= StCollect;
                    end
                end
                StCollect: begin
                    if (abort_i) begin
                        state_q <= StIdle;
                    end else if (beat_acc) begin
                        run_cnt_q <= run_sum;
                        if (bidx_q == LAST_BEAT || s_last_i) begin
                            result_q[widx_q*REG_WIDTH +: REG_WIDTH] <= word_next;
                            de_q[widx_q] <= 1'b1;
                            asm_q        <= '0;
                            bidx_q       <= '0;
                            widx_q       <= widx_q + WIDX_W'(1);
                            if (widx_q == LAST_WORD && bidx_q == LAST_BEAT) begin
                                done_q  <= 1'b1;
                                cnt_q   <= run_sum;
                                state_q <= StDone;
                            end else if (s_last_i) begin
                                short_q <= 1'b1;
                                done_q  <= 1'b1;
                                cnt_q   <= run_sum;
                                state_q <= StDone;
                            end
                        end else begin
                            asm_q  <= word_next;
                            bidx_q <= bidx_q + BIDX_W'(1);
                        end
                    end
                end
                StDone: begin
                    if (beat_acc) ovf_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign result_o      = result_q;
    assign result_de_o   = de_q;
    assign spike_count_o = cnt_q;
    assign busy_o        = (state_q == StCollect);
    assign done_o        = done_q;
    assign short_frame_o = short_q;
    assign overflow_o    = ovf_q;

endmodule
